// File: rtl/cpu_defs.sv
// Shared definitions for the multicycle MIPS datapath.
// HI/LO unit state encoding and write-back selector codes.
package cpu_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_t;

  localparam int ITERATIONS = 32;

  localparam logic [1:0] WB_SEL_HI = 2'd2;
  localparam logic [1:0] WB_SEL_LO = 2'd3;

endpackage

// File: rtl/mult_div_hilo_div_restore_step.sv
// One combinational restoring-division step on unsigned magnitudes.
// Caller guarantees rem_i < divisor_i, so the result fits WIDTH bits.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, divisor_i};
    if (diff[WIDTH]) begin
      rem_o = shifted[WIDTH-1:0];
      q_o   = 1'b0;
    end else begin
      rem_o = diff[WIDTH-1:0];
      q_o   = 1'b1;
    end
  end

endmodule

// File: rtl/mult_div_hilo.sv
// Iterative signed multiply (radix-2 Booth) / restoring divide unit
// producing the HI/LO registers for the write-back selector.
module mult_div_hilo
  import cpu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic [WIDTH-1:0] HI_out,
  output logic [WIDTH-1:0] LO_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  md_state_t        state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             qm1_q, qm1_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic             idle;
  logic             go_mult;
  logic             go_div;
  logic             dz_hit;
  logic             last_iter;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  // Multiply wins a simultaneous start; divide by zero never leaves IDLE.
  assign idle      = (state_q == ST_IDLE);
  assign go_mult   = idle & start_mult;
  assign go_div    = idle & ~start_mult & start_div & (B_in != '0);
  assign dz_hit    = idle & ~start_mult & start_div & (B_in == '0);
  assign last_iter = (cnt_q == 6'(ITERATIONS - 1));

  assign a_mag = A_in[WIDTH-1] ? -A_in : A_in;
  assign b_mag = B_in[WIDTH-1] ? -B_in : B_in;

  div_restore_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (acc_hi_q[WIDTH-1:0]),
    .divisor_i(opnd_q),
    .bit_i    (acc_lo_q[WIDTH-1]),
    .rem_o    (step_rem),
    .q_o      (step_q)
  );

  // One guard bit keeps -2^31 multiplicands from overflowing.
  always_comb begin
    m_ext = {opnd_q[WIDTH-1], opnd_q};
    unique case ({acc_lo_q[0], qm1_q})
      2'b01:   booth_sum = acc_hi_q + m_ext;
      2'b10:   booth_sum = acc_hi_q - m_ext;
      default: booth_sum = acc_hi_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (go_mult)     state_d = ST_MULT;
        else if (go_div) state_d = ST_DIV;
      end
      ST_MULT: if (last_iter) state_d = ST_FIX;
      ST_DIV:  if (last_iter) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_FIX) | dz_hit;
    dz_d   = dz_hit;
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    qm1_d    = qm1_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (go_mult) begin
          cnt_d    = '0;
          acc_hi_d = '0;
          acc_lo_d = B_in;
          opnd_d   = A_in;
          qm1_d    = 1'b0;
          negq_d   = 1'b0;
          negr_d   = 1'b0;
        end else if (go_div) begin
          cnt_d    = '0;
          acc_hi_d = '0;
          acc_lo_d = a_mag;
          opnd_d   = b_mag;
          qm1_d    = 1'b0;
          negq_d   = A_in[WIDTH-1] ^ B_in[WIDTH-1];
          negr_d   = A_in[WIDTH-1];
        end
      end
      ST_MULT: begin
        cnt_d    = cnt_q + 6'd1;
        acc_hi_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        acc_lo_d = {booth_sum[0], acc_lo_q[WIDTH-1:1]};
        qm1_d    = acc_lo_q[0];
      end
      ST_DIV: begin
        cnt_d    = cnt_q + 6'd1;
        acc_hi_d = {1'b0, step_rem};
        acc_lo_d = {acc_lo_q[WIDTH-2:0], step_q};
      end
      ST_FIX: begin
        hi_d = negr_q ? -acc_hi_q[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];
        lo_d = negq_q ? -acc_lo_q : acc_lo_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      qm1_q    <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      qm1_q    <= qm1_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign HI_out   = hi_q;
  assign LO_out   = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_hilo.sv
// Directed bench for mult_div_hilo: latency, results, div-by-zero,
// start arbitration and mid-operation reset.
module tb_mult_div_hilo;

  logic        clk;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] A_in;
  logic [31:0] B_in;
  logic [31:0] HI_out;
  logic [31:0] LO_out;
  logic        busy;
  logic        done;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  mult_div_hilo #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start_mult(start_mult),
    .start_div (start_div),
    .A_in      (A_in),
    .B_in      (B_in),
    .HI_out    (HI_out),
    .LO_out    (LO_out),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start an op in cycle 0; optionally pulse start_div at cycle inj.
  task automatic run_op(input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b,
                        input int inj, input logic [31:0] ehi,
                        input logic [31:0] elo, input string tag);
    A_in       = a;
    B_in       = b;
    start_mult = m;
    start_div  = d;
    tick();
    start_mult = 1'b0;
    start_div  = 1'b0;
    A_in       = 32'hDEAD_BEEF;
    B_in       = 32'h0000_0003;
    for (int c = 1; c <= 33; c++) begin
      check({tag, "_busy"}, {62'd0, busy, done}, 64'd2);
      if (c == inj) begin
        start_div = 1'b1;
        A_in      = 32'd100;
        B_in      = 32'd7;
      end
      tick();
      start_div = 1'b0;
    end
    check({tag, "_done"}, {61'd0, done, busy, div_zero}, 64'd4);
    check({tag, "_hi"}, {32'd0, HI_out}, {32'd0, ehi});
    check({tag, "_lo"}, {32'd0, LO_out}, {32'd0, elo});
    tick();
    check({tag, "_after"}, {62'd0, done, busy}, 64'd0);
    check({tag, "_hold"}, {HI_out, LO_out}, {ehi, elo});
  endtask

  initial begin
    logic saw_done;
    reset      = 1'b1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    A_in       = '0;
    B_in       = '0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_out", {HI_out, LO_out}, 64'd0);
      check("rst_flags", {61'd0, busy, done, div_zero}, 64'd0);
    end

    run_op(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd7, 0,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, "mul_m3x7");

    A_in      = 32'd55;
    B_in      = 32'd0;
    start_div = 1'b1;
    tick();
    start_div = 1'b0;
    B_in      = 32'd9;
    check("dz_flags", {61'd0, done, div_zero, busy}, 64'd6);
    check("dz_hold", {HI_out, LO_out}, 64'hFFFF_FFFF_FFFF_FFEB);
    tick();
    check("dz_after", {61'd0, done, div_zero, busy}, 64'd0);

    run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0,
           32'h3FFF_FFFF, 32'h0000_0001, "mul_max");
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 0,
           32'h4000_0000, 32'h0000_0000, "mul_min");
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7d2");
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0,
           32'h0000_0000, 32'h8000_0000, "div_ovf");
    run_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 0,
           32'h0000_0002, 32'hFFFF_FFF2, "div_100dm7");
    run_op(1'b1, 1'b1, 32'd5, 32'd3, 0,
           32'h0000_0000, 32'h0000_000F, "both_start");
    run_op(1'b1, 1'b0, 32'd6, 32'hFFFF_FFFE, 5,
           32'hFFFF_FFFF, 32'hFFFF_FFF4, "mul_busy_div");

    A_in       = 32'd1000;
    B_in       = 32'd1000;
    start_mult = 1'b1;
    tick();
    start_mult = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    reset = 1'b1;
    #1;
    check("mid_rst_out", {HI_out, LO_out}, 64'd0);
    check("mid_rst_flags", {61'd0, busy, done, div_zero}, 64'd0);
    tick();
    reset    = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    check("mid_rst_quiet", {63'd0, saw_done}, 64'd0);
    check("mid_rst_hold", {HI_out, LO_out}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
